// File: rtl/branch_pc_unit_pkg.sv
// Shared types and constants for the branch/PC unit slice.
// Optional feature macro: BRANCH_STATS_EN (adds branch statistics counters).
package branch_pc_pkg;

  // Fetch/execute sequencing states
  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_EXEC
  } state_t;

  // B-type funct3 condition codes
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Default PC values
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_PC  = 32'h0000_0100;

endpackage

// File: rtl/branch_pc_unit_if.sv
// Instruction-memory fetch handshake (req/gnt/rvalid).
// master = fetch side (branch_pc_unit), slave = instruction memory.
interface branch_pc_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/branch_pc_unit_cond_eval.sv
// Branch condition evaluation: maps funct3 plus comparator flags to a
// taken decision and selects signed/unsigned comparison.
module branch_cond_eval
  import branch_pc_pkg::*;
(
  input  logic [2:0] i_funct3,
  input  logic       i_br_eq,
  input  logic       i_br_lt,
  output logic       o_taken,
  output logic       o_br_un
);

  // funct3[1] distinguishes the unsigned compare variants
  assign o_br_un = i_funct3[1];

  // Taken decision; BGE/BGEU are taken on equality since br_lt is then 0
  always_comb begin
    o_taken = 1'b0;
    case (i_funct3)
      F3_BEQ:  o_taken = i_br_eq;
      F3_BNE:  o_taken = !i_br_eq;
      F3_BLT:  o_taken = i_br_lt;
      F3_BGE:  o_taken = !i_br_lt;
      F3_BLTU: o_taken = i_br_lt;
      F3_BGEU: o_taken = !i_br_lt;
      default: o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_pc_unit.sv
// Branch/jump resolution, PC register and single-outstanding instruction
// fetch sequencer. Optional macro BRANCH_STATS_EN adds saturating
// br_count/br_taken_count outputs; without it those ports do not exist.
module branch_pc_unit
  import branch_pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] TRAP_PC  = DEF_TRAP_PC
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  br_eq,
  input  logic                  br_lt,
  output logic                  br_un,
  input  logic                  is_branch,
  input  logic                  is_jal,
  input  logic                  is_jalr,
  input  logic [2:0]            funct3,
  input  logic [31:0]           target,
  input  logic                  retire,
  branch_pc_unit_if.master      imem,
  output logic [31:0]           instr,
  output logic                  instr_valid,
  output logic [31:0]           pc,
  output logic [31:0]           pc_plus4,
  output logic                  misalign_exc
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]           br_count,
  output logic [31:0]           br_taken_count
`endif
);

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic        r_instr_valid;
  logic        r_req;
  logic        r_exc;

  logic        w_taken;
  logic        w_redirect;
  logic [31:0] w_dest;
  logic        w_misalign;
  logic [31:0] w_next_pc;
  logic [31:0] w_pc_plus4;
  logic        w_retire_fire;

  branch_cond_eval u_cond (
    .i_funct3 (funct3),
    .i_br_eq  (br_eq),
    .i_br_lt  (br_lt),
    .o_taken  (w_taken),
    .o_br_un  (br_un)
  );

  assign w_pc_plus4    = r_pc + 32'd4;
  assign w_retire_fire = (r_state == S_EXEC) && retire;

  // Next-PC selection: jalr beats jal beats taken branch; misaligned redirect traps
  always_comb begin
    w_redirect = is_jalr || is_jal || (is_branch && w_taken);
    w_dest     = is_jalr ? {target[31:1], 1'b0} : target;
    w_misalign = w_redirect && w_dest[1];
    if (w_misalign)      w_next_pc = TRAP_PC;
    else if (w_redirect) w_next_pc = w_dest;
    else                 w_next_pc = w_pc_plus4;
  end

  // Fetch/execute FSM with PC, instruction capture and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC;
      r_instr       <= '0;
      r_instr_valid <= 1'b0;
      r_req         <= 1'b0;
      r_exc         <= 1'b0;
    end else begin
      r_exc <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_state <= S_REQ;
          r_req   <= 1'b1;
        end
        S_REQ: begin
          if (imem.imem_gnt) begin
            r_req <= 1'b0;
            if (imem.imem_rvalid) begin
              r_instr       <= imem.imem_rdata;
              r_instr_valid <= 1'b1;
              r_state       <= S_EXEC;
            end else begin
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (imem.imem_rvalid) begin
            r_instr       <= imem.imem_rdata;
            r_instr_valid <= 1'b1;
            r_state       <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (retire) begin
            r_pc          <= w_next_pc;
            r_exc         <= w_misalign;
            r_instr_valid <= 1'b0;
            r_req         <= 1'b1;
            r_state       <= S_REQ;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

`ifdef BRANCH_STATS_EN
  logic [31:0] r_br_count;
  logic [31:0] r_br_taken_count;

  // Saturating counters of retired branches and taken branches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_br_count       <= '0;
      r_br_taken_count <= '0;
    end else if (w_retire_fire && is_branch) begin
      if (r_br_count != '1)
        r_br_count <= r_br_count + 32'd1;
      if (w_taken && (r_br_taken_count != '1))
        r_br_taken_count <= r_br_taken_count + 32'd1;
    end
  end

  assign br_count       = r_br_count;
  assign br_taken_count = r_br_taken_count;
`else
  logic w_unused;
  assign w_unused = w_retire_fire;
`endif

  assign imem.imem_req  = r_req;
  assign imem.imem_addr = r_pc;
  assign instr          = r_instr;
  assign instr_valid    = r_instr_valid;
  assign pc             = r_pc;
  assign pc_plus4       = w_pc_plus4;
  assign misalign_exc   = r_exc;

endmodule

// File: tb/tb_branch_pc_unit.sv
// Self-checking bench for branch_pc_unit: reset, table of branch/jump
// vectors, fetch handshake corner cases, mid-fetch reset, random traffic.
module tb_branch_pc_unit;
  import branch_pc_pkg::*;

  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam logic [31:0] TPC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        br_eq, br_lt, br_un;
  logic        is_branch, is_jal, is_jalr;
  logic [2:0]  funct3;
  logic [31:0] target;
  logic        retire;
  logic [31:0] instr, pc, pc_plus4;
  logic        instr_valid, misalign_exc;
`ifdef BRANCH_STATS_EN
  logic [31:0] br_count, br_taken_count;
`endif

  branch_pc_unit_if u_if ();

  always #5 clk = ~clk;

  branch_pc_unit #(.RESET_PC(RPC), .TRAP_PC(TPC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .br_eq        (br_eq),
    .br_lt        (br_lt),
    .br_un        (br_un),
    .is_branch    (is_branch),
    .is_jal       (is_jal),
    .is_jalr      (is_jalr),
    .funct3       (funct3),
    .target       (target),
    .retire       (retire),
    .imem         (u_if),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .misalign_exc (misalign_exc)
`ifdef BRANCH_STATS_EN
    ,
    .br_count       (br_count),
    .br_taken_count (br_taken_count)
`endif
  );

  int          errors = 0;
  int          checks = 0;
  logic [31:0] m_pc;
  int unsigned m_brc, m_tkc;

  typedef struct {
    logic        b, j, jr;
    logic [2:0]  f3;
    logic        eq, lt;
    logic [31:0] tgt;
    logic [31:0] exp_pc;
    logic        exp_exc;
    logic        exp_tk;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_core();
    is_branch = 1'b0; is_jal = 1'b0; is_jalr = 1'b0;
    funct3 = 3'b000; br_eq = 1'b0; br_lt = 1'b0;
    target = '0; retire = 1'b0;
  endtask

  // Serve one fetch: gnt after gnt_dly stall cycles, rvalid rv_dly cycles after gnt
  task automatic fetch(input int gnt_dly, input int rv_dly, input logic [31:0] data);
    int n;
    n = 0;
    while (!u_if.imem_req && n < 20) begin tick(); n++; end
    if (!u_if.imem_req) begin
      chk("fetch_req_timeout", {31'b0, u_if.imem_req}, 32'd1);
      return;
    end
    chk("fetch_addr", u_if.imem_addr, m_pc);
    for (int i = 0; i < gnt_dly; i++) begin
      // retire while not executing must be ignored
      retire = 1'b1; is_jal = 1'b1; target = 32'h0000_ABC0;
      tick();
      chk("stall_req", {31'b0, u_if.imem_req}, 32'd1);
      chk("stall_valid", {31'b0, instr_valid}, 32'd0);
    end
    clear_core();
    if (gnt_dly > 0) chk("stall_pc", pc, m_pc);
    u_if.imem_gnt = 1'b1;
    if (rv_dly == 0) begin
      u_if.imem_rvalid = 1'b1;
      u_if.imem_rdata  = data;
    end
    tick();
    u_if.imem_gnt = 1'b0;
    u_if.imem_rvalid = 1'b0;
    if (rv_dly > 0) begin
      u_if.imem_rdata = 32'hBAD0_BAD0;
      for (int i = 1; i < rv_dly; i++) begin
        tick();
        chk("wait_req", {31'b0, u_if.imem_req}, 32'd0);
        chk("wait_valid", {31'b0, instr_valid}, 32'd0);
      end
      u_if.imem_rvalid = 1'b1;
      u_if.imem_rdata  = data;
      tick();
      u_if.imem_rvalid = 1'b0;
    end
    chk("fetch_valid", {31'b0, instr_valid}, 32'd1);
    chk("fetch_instr", instr, data);
  endtask

  // Present a resolved instruction, retire it, check the PC update
  task automatic retire_instr(input vec_t v, input string tag);
    is_branch = v.b; is_jal = v.j; is_jalr = v.jr;
    funct3 = v.f3; br_eq = v.eq; br_lt = v.lt; target = v.tgt;
    #1;
    chk({tag, "_br_un"}, {31'b0, br_un}, {31'b0, (v.f3 == 3'd2 || v.f3 == 3'd3 ||
                                                  v.f3 == 3'd6 || v.f3 == 3'd7)});
    retire = 1'b1;
    tick();
    clear_core();
    chk({tag, "_pc"}, pc, v.exp_pc);
    chk({tag, "_pc_plus4"}, pc_plus4, 32'(v.exp_pc + 32'd4));
    chk({tag, "_exc"}, {31'b0, misalign_exc}, {31'b0, v.exp_exc});
    chk({tag, "_valid_drop"}, {31'b0, instr_valid}, 32'd0);
    tick();
    chk({tag, "_exc_end"}, {31'b0, misalign_exc}, 32'd0);
    m_pc = v.exp_pc;
    if (v.b) begin
      m_brc++;
      if (v.exp_tk) m_tkc++;
    end
  endtask

  // Reference: architectural branch semantics on the compared operands
  function automatic logic ref_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) <  $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a <  b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic vec_t mk(input logic b, j, jr, input logic [2:0] f3, input logic eq, lt,
                              input logic [31:0] tgt, exp_pc, input logic exc, tk);
    vec_t v;
    v.b = b; v.j = j; v.jr = jr; v.f3 = f3; v.eq = eq; v.lt = lt;
    v.tgt = tgt; v.exp_pc = exp_pc; v.exp_exc = exc; v.exp_tk = tk;
    return v;
  endfunction

  initial begin
    vec_t        v;
    int          kind;
    logic [31:0] opa, opb, tgt, dest;
    logic [2:0]  f3;
    logic        tk, redir;

    clear_core();
    u_if.imem_gnt = 1'b0; u_if.imem_rvalid = 1'b0; u_if.imem_rdata = '0;
    m_pc = RPC; m_brc = 0; m_tkc = 0;

    // ---- reset state ----
    tick(); tick();
    chk("rst_pc", pc, RPC);
    chk("rst_instr", instr, 32'h0);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_req", {31'b0, u_if.imem_req}, 32'd0);
    chk("rst_exc", {31'b0, misalign_exc}, 32'd0);
    rst_n = 1'b1;

    // ---- first fetch: gnt+rvalid together ----
    fetch(0, 0, 32'h0000_0013);
    retire_instr(mk(0, 0, 0, 3'd0, 0, 0, 32'h0, 32'h4, 0, 0), "first");

    // ---- vector table (pc chain starts at 4) ----
    vecs.push_back(mk(1, 0, 0, 3'd0, 1, 0, 32'h40,   32'h40,   0, 1)); // BEQ taken
    vecs.push_back(mk(1, 0, 0, 3'd0, 0, 0, 32'h80,   32'h44,   0, 0)); // BEQ not
    vecs.push_back(mk(1, 0, 0, 3'd6, 0, 1, 32'h200,  32'h200,  0, 1)); // BLTU taken
    vecs.push_back(mk(1, 0, 0, 3'd4, 0, 0, 32'h300,  32'h204,  0, 0)); // BLT not
    vecs.push_back(mk(1, 0, 0, 3'd5, 1, 0, 32'h400,  32'h400,  0, 1)); // BGE on equal
    vecs.push_back(mk(1, 0, 0, 3'd7, 0, 1, 32'h500,  32'h404,  0, 0)); // BGEU not
    vecs.push_back(mk(1, 0, 0, 3'd1, 0, 0, 32'h600,  32'h600,  0, 1)); // BNE taken
    vecs.push_back(mk(1, 0, 0, 3'd2, 1, 1, 32'h700,  32'h604,  0, 0)); // 010 never
    vecs.push_back(mk(1, 0, 0, 3'd3, 1, 1, 32'h700,  32'h608,  0, 0)); // 011 never
    vecs.push_back(mk(0, 0, 1, 3'd0, 0, 0, 32'h81,   32'h80,   0, 0)); // JALR clears bit0
    vecs.push_back(mk(0, 1, 0, 3'd0, 0, 0, 32'h82,   TPC,      1, 0)); // JAL misaligned
    vecs.push_back(mk(1, 1, 1, 3'd0, 1, 0, 32'h1001, 32'h1000, 0, 1)); // jalr wins
    vecs.push_back(mk(1, 1, 0, 3'd0, 0, 0, 32'h2000, 32'h2000, 0, 0)); // jal beats not-taken
    vecs.push_back(mk(1, 0, 0, 3'd0, 1, 0, 32'h3002, TPC,      1, 1)); // branch misaligned
    vecs.push_back(mk(0, 0, 1, 3'd0, 0, 0, 32'h3,    TPC,      1, 0)); // JALR misaligned
    vecs.push_back(mk(0, 0, 0, 3'd0, 1, 0, 32'h5000, 32'h104,  0, 0)); // no control flow
    foreach (vecs[i]) begin
      fetch(i % 3, (i % 4 == 1) ? 2 : 0, 32'h1000_0000 + i);
      retire_instr(vecs[i], $sformatf("vec%0d", i));
    end

    // ---- long stall, late rvalid, rvalid while executing ----
    fetch(5, 3, 32'hCAFE_0001);
    u_if.imem_rvalid = 1'b1; u_if.imem_rdata = 32'hDEAD_BEEF;
    tick();
    u_if.imem_rvalid = 1'b0;
    chk("exec_rvalid_instr", instr, 32'hCAFE_0001);
    chk("exec_rvalid_valid", {31'b0, instr_valid}, 32'd1);
    retire_instr(mk(0, 0, 0, 3'd0, 0, 0, 32'h0, 32'(m_pc + 32'd4), 0, 0), "stall");

    // ---- pc wrap ----
    fetch(0, 1, 32'h0000_006F);
    retire_instr(mk(0, 1, 0, 3'd0, 0, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, 0), "to_top");
    fetch(1, 0, 32'h0000_0013);
    retire_instr(mk(0, 0, 0, 3'd0, 0, 0, 32'h0, 32'h0, 0, 0), "wrap");

`ifdef BRANCH_STATS_EN
    chk("br_count", br_count, 32'(m_brc));
    chk("br_taken_count", br_taken_count, 32'(m_tkc));
`endif

    // ---- reset during S_WAIT ----
    tick();
    u_if.imem_gnt = 1'b1;
    tick();
    u_if.imem_gnt = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_pc", pc, RPC);
    chk("midrst_req", {31'b0, u_if.imem_req}, 32'd0);
    chk("midrst_valid", {31'b0, instr_valid}, 32'd0);
    chk("midrst_instr", instr, 32'h0);
    chk("midrst_exc", {31'b0, misalign_exc}, 32'd0);
`ifdef BRANCH_STATS_EN
    chk("midrst_brc", br_count, 32'h0);
`endif
    tick();
    rst_n = 1'b1;
    u_if.imem_rvalid = 1'b1; u_if.imem_rdata = 32'h5A5A_5A5A;
    tick();
    u_if.imem_rvalid = 1'b0;
    chk("stale_valid", {31'b0, instr_valid}, 32'd0);
    chk("stale_instr", instr, 32'h0);
    tick();
    chk("stale_valid2", {31'b0, instr_valid}, 32'd0);
    m_pc = RPC; m_brc = 0; m_tkc = 0;

    // ---- random traffic against the reference model ----
    for (int i = 0; i < 40; i++) begin
      kind = int'($urandom_range(0, 3));
      f3   = 3'($urandom_range(0, 7));
      opa  = $urandom;
      opb  = ($urandom_range(0, 3) == 0) ? opa : $urandom;
      tgt  = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 5) == 0) tgt[1] = 1'b1;
      if (kind == 3) tgt[0] = 1'($urandom);
      tk    = ref_taken(f3, opa, opb);
      dest  = (kind == 3) ? (tgt & 32'hFFFF_FFFE) : tgt;
      redir = (kind >= 2) || (kind == 1 && tk);
      v = mk(kind == 1, kind == 2, kind == 3, f3, opa == opb,
             f3[1] ? (opa < opb) : ($signed(opa) < $signed(opb)), tgt,
             redir ? ((dest % 4 >= 2) ? TPC : dest) : 32'(m_pc + 32'd4),
             redir && (dest % 4 >= 2), tk);
      fetch(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom);
      retire_instr(v, $sformatf("rnd%0d", i));
    end
`ifdef BRANCH_STATS_EN
    chk("rnd_br_count", br_count, 32'(m_brc));
    chk("rnd_br_taken_count", br_taken_count, 32'(m_tkc));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors + 1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/branch_pc_unit.md
Name: branch_pc_unit

Overview:
- Consumes the branch comparator's BrEq/BrLT flags and drives its BrUn select.
- Resolves branch/jump outcome, owns the PC register, and sequences instruction fetch over a req/gnt/rvalid memory handshake.
- Sits between the comparator/ALU and instruction memory, one instruction in flight at a time.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- TRAP_PC, 32'h0000_0100, PC loaded on misaligned taken target.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- br_eq  in  1  comparator equal flag.
- br_lt  in  1  comparator less-than flag.
- br_un  out  1  comparator unsigned select; equals funct3[1] of held instruction.
- is_branch  in  1  held instruction is a B-type.
- is_jal  in  1  held instruction is JAL.
- is_jalr  in  1  held instruction is JALR.
- funct3  in  3  branch condition code.
- target  in  32  ALU-computed target address.
- retire  in  1  core finished held instruction; PC update permitted.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address, equals pc.
- imem_gnt  in  1  request accepted.
- imem_rvalid  in  1  fetch data valid.
- imem_rdata  in  32  fetch data.
- instr  out  32  captured instruction.
- instr_valid  out  1  instr is valid for the core.
- pc  out  32  address of held instruction.
- pc_plus4  out  32  pc + 4, modulo 2^32.
- misalign_exc  out  1  one-cycle pulse on misaligned taken target.

Behaviour:
- Reset, asynchronous on rst_n=0:
  - pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, misalign_exc=0, state=S_IDLE.
  - Reset asserted mid-fetch aborts the fetch; a stale rvalid is dropped because it arrives outside S_WAIT.
- FSM:
  - S_IDLE: one cycle after reset release -> S_REQ.
  - S_REQ: imem_req=1, imem_addr=pc.
    - imem_gnt=0: stay.
    - imem_gnt=1 with imem_rvalid=1 in the same cycle: capture, -> S_EXEC.
    - imem_gnt=1 otherwise: -> S_WAIT.
  - S_WAIT: imem_req=0. On imem_rvalid: instr<=imem_rdata, -> S_EXEC.
  - S_EXEC: instr_valid=1. On retire: pc<=next_pc, instr_valid<=0, -> S_REQ.
- imem_rvalid outside S_REQ/S_WAIT is ignored. retire outside S_EXEC is ignored.
- Taken decision (combinational):
  - funct3 000 BEQ = br_eq; 001 BNE = !br_eq; 100 BLT = br_lt; 101 BGE = !br_lt; 110 BLTU = br_lt; 111 BGEU = !br_lt.
  - 010 and 011 are never taken.
  - BGE/BGEU is taken on equality because br_lt=0.
- next_pc priority: is_jalr -> {target[31:1],1'b0}; else is_jal or (is_branch and taken) -> target; else pc_plus4.
  - Multiple of is_branch/is_jal/is_jalr set: jalr wins, then jal.
- Misalign: redirected target with bit[1]!=0 -> next_pc=TRAP_PC, misalign_exc=1 for the retire cycle only.
- All adds wrap modulo 2^32; pc=32'hFFFF_FFFC gives pc_plus4=0.
- Latency: fetch is at least 1 cycle (gnt and rvalid in the same cycle); redirect takes effect in the cycle after retire.

Optional Feature:
- BRANCH_STATS_EN defined:
  - Adds outputs br_count[31:0] and br_taken_count[31:0].
  - Both increment on retire of is_branch; br_taken_count only when taken.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Package branch_pc_pkg:
  - state enum (S_IDLE, S_REQ, S_WAIT, S_EXEC).
  - funct3 constants F3_BEQ..F3_BGEU.
  - Default RESET_PC/TRAP_PC localparams.
- Sub-module branch_cond_eval: combinational funct3/br_eq/br_lt -> taken, plus br_un.
- FSM and PC register remain in the top.

Test Plan:
- Reset release, gnt=1 and rvalid=1 same cycle, rdata=32'h0000_0013 -> imem_addr=0; instr=32'h13 with instr_valid=1 on cycle 2; retire -> pc=4.
- BEQ (funct3=000), br_eq=1, target=32'h40 -> pc=32'h40; br_eq=0 -> pc=4.
- BLTU (funct3=110) -> br_un=1; BLT (100) -> br_un=0; BGE with br_eq=1, br_lt=0 -> taken.
- JALR target=32'h0000_0081 -> pc=32'h80; JAL target=32'h0000_0082 -> pc=TRAP_PC, misalign_exc high for exactly 1 cycle.
- gnt held low 5 cycles, then gnt, rvalid 3 cycles later -> imem_req stays high through the stall; instr_valid rises only after rvalid; rvalid while idle is ignored.
- rst_n pulsed low during S_WAIT -> all outputs at reset values immediately; a later rvalid does not set instr_valid. Under BRANCH_STATS_EN: 3 branches, 2 taken -> counts 3 and 2.
